// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target buffer.
//   bp_entry_t        : one BTB entry (valid, tag, target, direction counter)
//   CTR_WEAK_T/_NT    : weakly-taken / weakly-not-taken counter encodings
//   bp_index / bp_tag : PC field extraction for a given IDX_W / TAG_W
// Entry fields are sized for the largest supported configuration
// (XLEN <= 64, TAG_W <= 32, CTR_W <= 8). Narrower configurations keep the
// unused upper bits at zero, so full-width compares stay correct.
package bp_pkg;

  localparam int BP_MAX_XLEN  = 64;
  localparam int BP_MAX_TAG_W = 32;
  localparam int BP_MAX_CTR_W = 8;

  typedef struct packed {
    logic                    valid;
    logic [BP_MAX_TAG_W-1:0] tag;
    logic [BP_MAX_XLEN-1:0]  target;
    logic [BP_MAX_CTR_W-1:0] ctr;
  } bp_entry_t;

  // 1 followed by ctr_w-1 zeros
  function automatic logic [BP_MAX_CTR_W-1:0] CTR_WEAK_T(input int ctr_w);
    return BP_MAX_CTR_W'(1) << (ctr_w - 1);
  endfunction

  // 0 followed by ctr_w-1 ones
  function automatic logic [BP_MAX_CTR_W-1:0] CTR_WEAK_NT(input int ctr_w);
    return CTR_WEAK_T(ctr_w) - BP_MAX_CTR_W'(1);
  endfunction

  // pc[idx_w+1:2]
  function automatic logic [31:0] bp_index(input logic [BP_MAX_XLEN-1:0] pc,
                                           input int idx_w);
    logic [BP_MAX_XLEN-1:0] mask;
    mask = (BP_MAX_XLEN'(1) << idx_w) - BP_MAX_XLEN'(1);
    return 32'((pc >> 2) & mask);
  endfunction

  // pc[idx_w+1+tag_w:idx_w+2]
  function automatic logic [BP_MAX_TAG_W-1:0] bp_tag(input logic [BP_MAX_XLEN-1:0] pc,
                                                     input int idx_w,
                                                     input int tag_w);
    logic [BP_MAX_XLEN-1:0] mask;
    mask = (BP_MAX_XLEN'(1) << tag_w) - BP_MAX_XLEN'(1);
    return BP_MAX_TAG_W'((pc >> (idx_w + 2)) & mask);
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Combinational saturating up/down counter step.
//   ctr      : current value
//   up       : 1 = increment, 0 = decrement
//   ctr_next : next value, held at all-ones / zero instead of wrapping
module bp_sat_ctr #(
  parameter int W = 2
) (
  input  logic [W-1:0] ctr,
  input  logic         up,
  output logic [W-1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (up) begin
      if (ctr != '1) ctr_next = ctr + W'(1);
    end else begin
      if (ctr != '0) ctr_next = ctr - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Branch target buffer with saturating direction counters for the IF stage.
//   clk, reset (async, active low)
//   lookup_pc -> pred_taken, pred_target        : same-cycle prediction
//   upd_*     -> mispredict, redirect_pc         : same-cycle resolution from EX
//   invalidate                                   : clear every valid bit
//   hit_count, mispredict_count                  : saturating statistics
// Table writes land on the clock edge, so a lookup and an update of the same
// index in one cycle see the old contents (no bypass).
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   lookup_pc,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [XLEN-1:0]   upd_pred_target,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  input  logic              invalidate,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);

  bp_entry_t table_q [ENTRIES];

  logic [IDX_W-1:0]        lookup_idx;
  logic [BP_MAX_TAG_W-1:0] lookup_tag;
  logic                    lookup_hit;

  logic [IDX_W-1:0]        upd_idx;
  logic [BP_MAX_TAG_W-1:0] upd_tag;
  bp_entry_t               upd_entry;
  bp_entry_t               upd_entry_next;
  logic                    upd_hit;
  logic                    upd_write;
  logic [CTR_W-1:0]        upd_ctr_next;

  logic [STAT_W-1:0]       hit_count_reg;
  logic [STAT_W-1:0]       hit_count_next;
  logic [STAT_W-1:0]       mispredict_count_reg;
  logic [STAT_W-1:0]       mispredict_count_next;

  // ---------------- lookup ----------------
  assign lookup_idx = IDX_W'(bp_index(BP_MAX_XLEN'(lookup_pc), IDX_W));
  assign lookup_tag = bp_tag(BP_MAX_XLEN'(lookup_pc), IDX_W, TAG_W);

  // Table is held cleared while reset is low, so no explicit reset gating
  // is needed here.
  assign lookup_hit  = table_q[lookup_idx].valid && (table_q[lookup_idx].tag == lookup_tag);
  assign pred_taken  = lookup_hit && table_q[lookup_idx].ctr[CTR_W-1];
  assign pred_target = pred_taken ? table_q[lookup_idx].target[XLEN-1:0]
                                  : lookup_pc + XLEN'(4);

  // ---------------- resolution ----------------
  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

  // ---------------- update ----------------
  assign upd_idx   = IDX_W'(bp_index(BP_MAX_XLEN'(upd_pc), IDX_W));
  assign upd_tag   = bp_tag(BP_MAX_XLEN'(upd_pc), IDX_W, TAG_W);
  assign upd_entry = table_q[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  bp_sat_ctr #(.W(CTR_W)) u_dir_ctr (
    .ctr      (upd_entry.ctr[CTR_W-1:0]),
    .up       (upd_taken),
    .ctr_next (upd_ctr_next)
  );

  always_comb begin
    upd_entry_next = upd_entry;
    upd_write      = 1'b0;
    if (upd_valid) begin
      if (upd_hit) begin
        upd_write          = 1'b1;
        upd_entry_next.ctr = BP_MAX_CTR_W'(upd_ctr_next);
        if (upd_taken) upd_entry_next.target = BP_MAX_XLEN'(upd_target);
      end else if (upd_taken) begin
        // Allocate, evicting whatever aliased into this slot.
        upd_write             = 1'b1;
        upd_entry_next.valid  = 1'b1;
        upd_entry_next.tag    = upd_tag;
        upd_entry_next.target = BP_MAX_XLEN'(upd_target);
        upd_entry_next.ctr    = CTR_WEAK_T(CTR_W);
      end
      // Miss, not taken: nothing worth remembering.
    end
  end

  // ---------------- statistics ----------------
  bp_sat_ctr #(.W(STAT_W)) u_hit_stat (
    .ctr      (hit_count_reg),
    .up       (1'b1),
    .ctr_next (hit_count_next)
  );

  bp_sat_ctr #(.W(STAT_W)) u_mp_stat (
    .ctr      (mispredict_count_reg),
    .up       (1'b1),
    .ctr_next (mispredict_count_next)
  );

  assign hit_count        = hit_count_reg;
  assign mispredict_count = mispredict_count_reg;

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid  <= 1'b0;
        table_q[i].tag    <= '0;
        table_q[i].target <= '0;
        table_q[i].ctr    <= CTR_WEAK_NT(CTR_W);
      end
      hit_count_reg        <= '0;
      mispredict_count_reg <= '0;
    end else begin
      // Invalidate takes priority and drops a coincident update.
      if (invalidate) begin
        for (int i = 0; i < ENTRIES; i++) begin
          table_q[i].valid <= 1'b0;
        end
      end else if (upd_write) begin
        table_q[upd_idx] <= upd_entry_next;
      end
      if (lookup_hit) hit_count_reg        <= hit_count_next;
      if (mispredict) mispredict_count_reg <= mispredict_count_next;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (ENTRIES=16, TAG_W=8,
// CTR_W=2, STAT_W=4 so counter saturation is reachable quickly).
// Index = pc[5:2], tag = pc[13:6]. 0x100, 0x1100 and 0x300 share index 0
// with tags 0x04, 0x44 and 0x0C; 0x4100 also has tag 0x04 in 8 bits.
module tb_branch_predictor;

  localparam int XLEN   = 64;
  localparam int STAT_W = 4;
  localparam int STAT_MAX = 15;

  logic              clk;
  logic              reset;
  logic [XLEN-1:0]   lookup_pc;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_target;
  logic              upd_valid;
  logic [XLEN-1:0]   upd_pc;
  logic              upd_taken;
  logic [XLEN-1:0]   upd_target;
  logic              upd_pred_taken;
  logic [XLEN-1:0]   upd_pred_target;
  logic              mispredict;
  logic [XLEN-1:0]   redirect_pc;
  logic              invalidate;
  logic [STAT_W-1:0] hit_count;
  logic [STAT_W-1:0] mispredict_count;

  branch_predictor #(
    .XLEN(XLEN), .ENTRIES(16), .TAG_W(8), .CTR_W(2), .STAT_W(STAT_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .lookup_pc        (lookup_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .invalidate       (invalidate),
    .hit_count        (hit_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] lpc;
    logic        uv;
    logic [63:0] upc;
    logic        ut;
    logic [63:0] utgt;
    logic        upt;
    logic [63:0] uptgt;
    logic        inv;
    logic        e_pt;
    logic [63:0] e_tgt;
    logic        e_hit;
    logic        e_mp;
    logic [63:0] e_redir;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int exp_hits = 0;
  int exp_mps = 0;
  vec_t vecs [20];

  function automatic vec_t mk(logic [63:0] lpc, logic uv, logic [63:0] upc, logic ut,
                              logic [63:0] utgt, logic upt, logic [63:0] uptgt, logic inv,
                              logic e_pt, logic [63:0] e_tgt, logic e_hit, logic e_mp,
                              logic [63:0] e_redir);
    vec_t v;
    v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.upt = upt; v.uptgt = uptgt; v.inv = inv;
    v.e_pt = e_pt; v.e_tgt = e_tgt; v.e_hit = e_hit; v.e_mp = e_mp; v.e_redir = e_redir;
    return v;
  endfunction

  // Lookup only; update inputs idle (redirect_pc = 0 + 4).
  function automatic vec_t lk(logic [63:0] lpc, logic e_pt, logic [63:0] e_tgt, logic e_hit);
    return mk(lpc, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0,
              e_pt, e_tgt, e_hit, 1'b0, 64'h4);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input int id, input vec_t v);
    @(negedge clk);
    lookup_pc       = v.lpc;
    upd_valid       = v.uv;
    upd_pc          = v.upc;
    upd_taken       = v.ut;
    upd_target      = v.utgt;
    upd_pred_taken  = v.upt;
    upd_pred_target = v.uptgt;
    invalidate      = v.inv;
    #1;
    $display("vec %0d: lookup %0h upd_v %0b upd_pc %0h taken %0b -> pt %0b tgt %0h mp %0b redir %0h",
             id, v.lpc, v.uv, v.upc, v.ut, pred_taken, pred_target, mispredict, redirect_pc);
    chk($sformatf("v%0d pred_taken", id),  64'(pred_taken), 64'(v.e_pt));
    chk($sformatf("v%0d pred_target", id), pred_target, v.e_tgt);
    chk($sformatf("v%0d mispredict", id),  64'(mispredict), 64'(v.e_mp));
    chk($sformatf("v%0d redirect_pc", id), redirect_pc, v.e_redir);
    @(posedge clk);
    if (v.e_hit && exp_hits < STAT_MAX) exp_hits++;
    if (v.e_mp && exp_mps < STAT_MAX) exp_mps++;
    #1;
    chk($sformatf("v%0d hit_count", id),        64'(hit_count), 64'(exp_hits));
    chk($sformatf("v%0d mispredict_count", id), 64'(mispredict_count), 64'(exp_mps));
  endtask

  task automatic idle_inputs();
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_target = '0; invalidate = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    lookup_pc = '0;
    idle_inputs();

    // ---- reset state ----
    #1;
    chk("reset hit_count", 64'(hit_count), 64'd0);
    chk("reset mispredict_count", 64'(mispredict_count), 64'd0);
    chk("reset pred_taken", 64'(pred_taken), 64'd0);
    chk("reset pred_target", pred_target, 64'h4);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    //              lpc     uv upc      ut utgt     upt uptgt    inv  pt tgt      hit mp redir
    vecs[0]  = lk(64'h100, 0, 64'h104, 0);
    vecs[1]  = mk(64'h100, 1, 64'h100,  1, 64'h80,  0, 64'h104,  0,   0, 64'h104, 0, 1, 64'h80);
    vecs[2]  = lk(64'h100, 1, 64'h80, 1);
    vecs[3]  = mk(64'h100, 1, 64'h100,  0, 64'h0,   1, 64'h80,   0,   1, 64'h80,  1, 1, 64'h104);
    vecs[4]  = mk(64'h100, 1, 64'h100,  0, 64'h0,   0, 64'h104,  0,   0, 64'h104, 1, 0, 64'h104);
    vecs[5]  = mk(64'h100, 1, 64'h100,  0, 64'h0,   0, 64'h104,  0,   0, 64'h104, 1, 0, 64'h104);
    // ctr 00 -> 01 (must not have wrapped to 11)
    vecs[6]  = mk(64'h100, 1, 64'h100,  1, 64'h80,  0, 64'h104,  0,   0, 64'h104, 1, 1, 64'h80);
    // ctr 01 -> 10, target replaced with 0x90
    vecs[7]  = mk(64'h100, 1, 64'h100,  1, 64'h90,  0, 64'h104,  0,   0, 64'h104, 1, 1, 64'h90);
    // right direction, wrong target -> mispredict; ctr 10 -> 11
    vecs[8]  = mk(64'h100, 1, 64'h100,  1, 64'h90,  1, 64'h80,   0,   1, 64'h90,  1, 1, 64'h90);
    vecs[9]  = mk(64'h100, 1, 64'h100,  1, 64'h90,  1, 64'h90,   0,   1, 64'h90,  1, 0, 64'h90);
    // alias: 0x1100 overwrites slot 0
    vecs[10] = mk(64'h1100, 1, 64'h1100, 1, 64'h200, 0, 64'h1104, 0,  0, 64'h1104, 0, 1, 64'h200);
    vecs[11] = lk(64'h100, 0, 64'h104, 0);
    vecs[12] = lk(64'h1100, 1, 64'h200, 1);
    vecs[13] = lk(64'h4100, 0, 64'h4104, 0);
    // miss, not taken: no allocation
    vecs[14] = mk(64'h208, 1, 64'h208,  0, 64'h0,   0, 64'h20c,  0,   0, 64'h20c, 0, 0, 64'h20c);
    vecs[15] = lk(64'h208, 0, 64'h20c, 0);
    // invalidate + update together: lookup sees old table, update dropped
    vecs[16] = mk(64'h1100, 1, 64'h208, 1, 64'h300, 0, 64'h20c,  1,   1, 64'h200, 1, 1, 64'h300);
    vecs[17] = lk(64'h1100, 0, 64'h1104, 0);
    vecs[18] = lk(64'h208, 0, 64'h20c, 0);
    // re-allocate 0x100 for the saturation run
    vecs[19] = mk(64'h208, 1, 64'h100,  1, 64'h80,  0, 64'h104,  0,   0, 64'h20c, 0, 1, 64'h80);

    for (int i = 0; i < 20; i++) apply(i, vecs[i]);

    // ---- statistics saturation: 20 hitting lookups + 20 mispredicts ----
    for (int i = 0; i < 20; i++) begin
      apply(100 + i, mk(64'h100, 1, 64'h300, 0, 64'h0, 1, 64'h304, 0,
                        1, 64'h80, 1, 1, 64'h304));
    end
    chk("sat hit_count", 64'(hit_count), 64'd15);
    chk("sat mispredict_count", 64'(mispredict_count), 64'd15);

    // ---- asynchronous reset mid-cycle ----
    @(negedge clk);
    lookup_pc = 64'h100;
    upd_valid = 1'b1; upd_pc = 64'h300; upd_taken = 1'b0;
    upd_pred_taken = 1'b1; upd_pred_target = 64'h304; invalidate = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    $display("async reset: hit_count %0d mispredict_count %0d pt %0b mp %0b",
             hit_count, mispredict_count, pred_taken, mispredict);
    chk("async hit_count", 64'(hit_count), 64'd0);
    chk("async mispredict_count", 64'(mispredict_count), 64'd0);
    chk("async pred_taken", 64'(pred_taken), 64'd0);
    chk("async pred_target", pred_target, 64'h104);
    chk("async mispredict", 64'(mispredict), 64'd1);
    chk("async redirect_pc", redirect_pc, 64'h304);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    exp_hits = 0;
    exp_mps = 0;
    apply(200, lk(64'h100, 0, 64'h104, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
